// File: rtl/density_request_gen.sv
// density_request_gen: per-side vehicle density request generator.
// Each side synchronises its raw detector, detects rising edges with a
// holdoff against detector bounce, counts vehicles over a shared time window
// and raises a density request (p1/p2) when enough vehicles are waiting. The
// request is held until that side's green lamp services it.
// Optional build macro: TLC_DENSITY_AGE_EN enables anti-starvation aging, so a
// small nonzero count that survives AGE_MAX windows still raises a request.

module density_side #(
  parameter int CW      = 4,
  parameter int THRESH  = 3,
  parameter int GAP_CYC = 2
`ifdef TLC_DENSITY_AGE_EN
  ,
  parameter int AGE_MAX = 4
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          veh,
  input  logic          green,
  input  logic          win_end,
  output logic          p,
  output logic [CW-1:0] cnt
);

  // Holdoff counter is sized so that GAP_CYC always fits.
  localparam int HW = $clog2(GAP_CYC + 2);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [HW-1:0] HOLD_LD  = HW'(GAP_CYC);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

`ifdef TLC_DENSITY_AGE_EN
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);
  localparam logic [AW-1:0] AGE_ONE = AW'(1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } state_t;

  // Saturating vehicle counter increment: stops at all-ones, never wraps.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  logic          sync1_r;
  logic          sync2_r;
  logic          prev_r;
  logic [HW-1:0] hold_r;
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          p_r;

  logic          edge_raw_s;
  logic          acc_edge_s;
  logic [CW-1:0] cnt_inc_s;
  logic [CW-1:0] idle_cnt_nxt_s;
  logic          idle_req_s;

`ifdef TLC_DENSITY_AGE_EN
  logic [AW-1:0] age_r;
  logic [AW-1:0] idle_age_nxt_s;
`endif

  // Two-flop synchroniser for the asynchronous detector plus the edge-detect history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= veh;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Edge qualification and next-count computation for the IDLE state.
  always_comb begin
    edge_raw_s     = 1'b0;
    acc_edge_s     = 1'b0;
    cnt_inc_s      = cnt_r;
    idle_cnt_nxt_s = cnt_r;
    idle_req_s     = 1'b0;
`ifdef TLC_DENSITY_AGE_EN
    idle_age_nxt_s = age_r;
`endif

    edge_raw_s = sync2_r & ~prev_r;
    if (hold_r == '0) begin
      acc_edge_s = edge_raw_s;
    end else begin
      acc_edge_s = 1'b0;
    end
    cnt_inc_s = sat_inc(cnt_r);

`ifdef TLC_DENSITY_AGE_EN
    // Window end does not clear a pending count; it ages it instead.
    if (acc_edge_s) begin
      idle_cnt_nxt_s = cnt_inc_s;
    end else begin
      idle_cnt_nxt_s = cnt_r;
    end
    if (idle_cnt_nxt_s == '0) begin
      idle_age_nxt_s = '0;
    end else if (win_end && (cnt_r != '0) && (age_r != AGE_LIM)) begin
      idle_age_nxt_s = age_r + AGE_ONE;
    end else begin
      idle_age_nxt_s = age_r;
    end
    idle_req_s = (idle_cnt_nxt_s >= THRESH_C) ||
                 ((idle_cnt_nxt_s != '0) && (idle_age_nxt_s == AGE_LIM));
`else
    // A vehicle arriving on the window boundary opens the new window with a count of one.
    if (acc_edge_s) begin
      if (win_end) begin
        idle_cnt_nxt_s = CNT_ONE;
      end else begin
        idle_cnt_nxt_s = cnt_inc_s;
      end
    end else if (win_end) begin
      idle_cnt_nxt_s = '0;
    end else begin
      idle_cnt_nxt_s = cnt_r;
    end
    idle_req_s = (idle_cnt_nxt_s >= THRESH_C);
`endif
  end

  // Holdoff: an accepted edge blocks further edges for GAP_CYC cycles (detector bounce).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
    end else if (acc_edge_s) begin
      hold_r <= HOLD_LD;
    end else if (hold_r != '0) begin
      hold_r <= hold_r - HOLD_ONE;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Request FSM with registered count and request outputs; green always has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      p_r     <= 1'b0;
`ifdef TLC_DENSITY_AGE_EN
      age_r   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (green) begin
            state_r <= SERVE;
            cnt_r   <= '0;
            p_r     <= 1'b0;
`ifdef TLC_DENSITY_AGE_EN
            age_r   <= '0;
`endif
          end else begin
            cnt_r <= idle_cnt_nxt_s;
`ifdef TLC_DENSITY_AGE_EN
            age_r <= idle_age_nxt_s;
`endif
            if (idle_req_s) begin
              state_r <= REQ;
              p_r     <= 1'b1;
            end else begin
              state_r <= IDLE;
              p_r     <= 1'b0;
            end
          end
        end
        REQ: begin
          if (green) begin
            state_r <= SERVE;
            cnt_r   <= '0;
            p_r     <= 1'b0;
`ifdef TLC_DENSITY_AGE_EN
            age_r   <= '0;
`endif
          end else begin
            state_r <= REQ;
            p_r     <= 1'b1;
            if (acc_edge_s) begin
              cnt_r <= cnt_inc_s;
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        SERVE: begin
          cnt_r <= '0;
          p_r   <= 1'b0;
`ifdef TLC_DENSITY_AGE_EN
          age_r <= '0;
`endif
          if (green) begin
            state_r <= SERVE;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          p_r     <= 1'b0;
`ifdef TLC_DENSITY_AGE_EN
          age_r   <= '0;
`endif
        end
      endcase
    end
  end

  assign p   = p_r;
  assign cnt = cnt_r;

endmodule

module density_request_gen #(
  parameter int CW      = 4,
  parameter int THRESH  = 3,
  parameter int WIN_CYC = 64,
  parameter int GAP_CYC = 2
`ifdef TLC_DENSITY_AGE_EN
  ,
  parameter int AGE_MAX = 4
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          veh1,
  input  logic          veh2,
  input  logic          s1green,
  input  logic          s2green,
  output logic          p1,
  output logic          p2,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2
);

  // Window counter width; WIN_CYC is expected to be at least 2.
  localparam int WW = $clog2(WIN_CYC);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYC - 1);
  localparam logic [WW-1:0] WIN_ONE  = WW'(1);

  logic [WW-1:0] win_cnt_r;
  logic          win_end_s;

  // Shared free-running window counter 0..WIN_CYC-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_r <= '0;
    end else if (win_cnt_r == WIN_LAST) begin
      win_cnt_r <= '0;
    end else begin
      win_cnt_r <= win_cnt_r + WIN_ONE;
    end
  end

  assign win_end_s = (win_cnt_r == WIN_LAST);

  density_side #(
    .CW      (CW),
    .THRESH  (THRESH),
    .GAP_CYC (GAP_CYC)
`ifdef TLC_DENSITY_AGE_EN
    ,
    .AGE_MAX (AGE_MAX)
`endif
  ) u_side1 (
    .clk     (clk),
    .rst     (rst),
    .veh     (veh1),
    .green   (s1green),
    .win_end (win_end_s),
    .p       (p1),
    .cnt     (cnt1)
  );

  density_side #(
    .CW      (CW),
    .THRESH  (THRESH),
    .GAP_CYC (GAP_CYC)
`ifdef TLC_DENSITY_AGE_EN
    ,
    .AGE_MAX (AGE_MAX)
`endif
  ) u_side2 (
    .clk     (clk),
    .rst     (rst),
    .veh     (veh2),
    .green   (s2green),
    .win_end (win_end_s),
    .p       (p2),
    .cnt     (cnt2)
  );

endmodule

// File: tb/tb_density_request_gen.sv
// Directed bench for density_request_gen (default build, aging disabled).
// cyc_r mirrors the window phase: the count of rising edges since reset
// release, so the window-clearing edge is the one that makes cyc_r % 64 == 0.

module tb_density_request_gen;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       veh1    = 1'b0;
  logic       veh2    = 1'b0;
  logic       s1green = 1'b0;
  logic       s2green = 1'b0;
  logic       p1;
  logic       p2;
  logic [3:0] cnt1;
  logic [3:0] cnt2;

  int cyc_r    = 0;
  int checks   = 0;
  int failures = 0;

  density_request_gen dut (
    .clk     (clk),
    .rst     (rst),
    .veh1    (veh1),
    .veh2    (veh2),
    .s1green (s1green),
    .s2green (s2green),
    .p1      (p1),
    .p2      (p2),
    .cnt1    (cnt1),
    .cnt2    (cnt2)
  );

  always #5 clk = ~clk;

  // Bench model of the window phase.
  always @(posedge clk) begin
    if (rst) cyc_r <= 0;
    else     cyc_r <= cyc_r + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, obs, exp, cyc_r);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    while ((cyc_r % 64) != 0) tick(1);
  endtask

  task automatic pulse(input int side, input int hi, input int lo);
    if (side == 1) veh1 = 1'b1;
    else           veh2 = 1'b1;
    tick(hi);
    if (side == 1) veh1 = 1'b0;
    else           veh2 = 1'b0;
    tick(lo);
  endtask

  // One 4-high/6-low veh1 pulse; count must change exactly on the 3rd edge.
  task automatic pulse1_chk(input int exp_cnt, input logic exp_p);
    veh1 = 1'b1;
    tick(2);
    check("t2_cnt1_before", cnt1, exp_cnt - 1);
    tick(1);
    check("t2_cnt1_after", cnt1, exp_cnt);
    check("t2_p1", p1, exp_p);
    check("t2_p2", p2, 1'b0);
    tick(1);
    veh1 = 1'b0;
    tick(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Test 1: reset and idle.
    tick(3);
    check("t1_in_reset", {p1, p2, cnt1, cnt2}, 10'd0);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      check("t1_idle", {p1, p2, cnt1, cnt2}, 10'd0);
    end

    // Test 2: three vehicles in one window raise p1.
    align();
    pulse1_chk(1, 1'b0);
    pulse1_chk(2, 1'b0);
    pulse1_chk(3, 1'b1);
    align();
    check("t2_req_keeps_cnt", cnt1, 4'd3);
    check("t2_req_keeps_p", p1, 1'b1);

    // Test 3: service by green, edges discarded during green.
    s1green = 1'b1;
    tick(1);
    check("t3_serve_p1", p1, 1'b0);
    check("t3_serve_cnt1", cnt1, 4'd0);
    pulse(1, 4, 6);
    pulse(1, 4, 6);
    check("t3_green_cnt1", cnt1, 4'd0);
    s1green = 1'b0;
    tick(1);
    veh1 = 1'b1;
    tick(3);
    check("t3_idle_cnt1", cnt1, 4'd1);
    tick(1);
    veh1 = 1'b0;
    tick(6);

    // Test 4: window end clears an unmet count.
    pulse(2, 4, 6);
    pulse(2, 4, 6);
    check("t4_cnt2", cnt2, 4'd2);
    check("t4_p2", p2, 1'b0);
    check("t4_cnt1_indep", cnt1, 4'd1);
    while (cyc_r != 383) tick(1);
    check("t4_cnt2_pre_win", cnt2, 4'd2);
    tick(1);
    check("t4_cnt2_win", cnt2, 4'd0);
    check("t4_p2_win", p2, 1'b0);
    check("t4_cnt1_win", cnt1, 4'd0);

    // Test 5: bounce, long hold, saturation.
    veh1 = 1'b1; tick(1);
    veh1 = 1'b0; tick(1);
    veh1 = 1'b1; tick(1);
    veh1 = 1'b0; tick(8);
    check("t5_bounce_cnt1", cnt1, 4'd1);
    align();
    check("t5_cnt1_cleared", cnt1, 4'd0);
    veh2 = 1'b1;
    tick(50);
    veh2 = 1'b0;
    tick(5);
    check("t5_hold_cnt2", cnt2, 4'd1);
    check("t5_hold_p2", p2, 1'b0);
    align();
    for (int i = 0; i < 15; i++) pulse(2, 2, 2);
    check("t5_cnt2_15", cnt2, 4'd15);
    check("t5_p2_req", p2, 1'b1);
    for (int i = 0; i < 8; i++) pulse(2, 2, 2);
    check("t5_cnt2_sat", cnt2, 4'd15);
    s2green = 1'b1;
    tick(1);
    check("t5_serve_p2", p2, 1'b0);
    check("t5_serve_cnt2", cnt2, 4'd0);
    s2green = 1'b0;
    tick(1);

    // Test 6: async reset mid-request, then edge on window end.
    align();
    for (int i = 0; i < 5; i++) pulse(1, 2, 2);
    check("t6_cnt1_5", cnt1, 4'd5);
    check("t6_p1_req", p1, 1'b1);
    rst = 1'b1;
    #2;
    check("t6_async_p1", p1, 1'b0);
    check("t6_async_cnt1", cnt1, 4'd0);
    tick(2);
    rst = 1'b0;
    pulse(1, 2, 2);
    pulse(1, 2, 2);
    check("t6_cnt1_2", cnt1, 4'd2);
    while (cyc_r != 61) tick(1);
    veh1 = 1'b1;
    tick(2);
    check("t6_pre_win_cnt1", cnt1, 4'd2);
    tick(1);
    check("t6_edge_win_cnt1", cnt1, 4'd1);
    check("t6_edge_win_p1", p1, 1'b0);
    veh1 = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
